cp0_nested: RTL
===============

CP0_NESTED -- requirements
Module: cp0_nested

Interface
REQ-001 Parameter NUM_IRQ, default 4: external interrupt lines, range 1..8.
REQ-002 Parameter DEPTH, default 4: saved-context stack entries, range 1..8.
REQ-003 Parameter VECTOR, default 32'h0000_0004: handler entry address.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 mfc0  in  1  read strobe; mtc0  in  1  write strobe.
REQ-007 addr  in  5  CP0 register select: 12 Status, 13 Cause, 14 EPC.
REQ-008 wdata  in  32  mtc0 write data.
REQ-009 pc  in  32  address of the faulting or interrupted instruction.
REQ-010 exception  in  1  synchronous exception request.
REQ-011 cause  in  5  exception code: 8 syscall, 9 break, 13 teq.
REQ-012 eret  in  1  return from exception.
REQ-013 irq  in  NUM_IRQ  level-sensitive external interrupt lines.
REQ-014 rdata  out  32  mfc0 read data; status  out  32  Status register.
REQ-015 exc_addr  out  32  redirect target; exc_taken  out  1  redirect valid this cycle.
REQ-016 nest_level  out  4  number of occupied stack entries.
REQ-017 overflow  out  1  sticky: an entry was refused because the stack was full.

Function
REQ-018 Status layout: [0] IE, [1] syscall enable, [2] break enable, [3] teq enable, [8+i] IM[i], [31] overflow; all other bits read 0, writes to them are ignored.
REQ-019 Cause layout: [6:2] ExcCode, [8+i] IP[i]; other bits read 0.
REQ-020 IP[i] sets on any edge where irq[i]=1; IP[i] clears only when interrupt i is taken or an mtc0 to Cause writes bit 8+i to 0; mtc0 cannot set IP.
REQ-021 A synchronous exception is accepted when exception=1, IE=1, and the enable bit for cause is 1; unknown causes and disabled causes are ignored.
REQ-022 An interrupt is accepted when no synchronous exception is accepted, eret=0, IE=1, and (IP & IM)!=0; the lowest-index pending line wins, and ExcCode is set to 0.
REQ-023 Acceptance is combinational: exc_taken=1 and exc_addr=VECTOR in the same cycle.
REQ-024 On the next edge after acceptance: stack[nest_level] <= {EPC, Status}; EPC <= pc; ExcCode is written; IE <= 0; nest_level increments.
REQ-025 When an event qualifies but nest_level==DEPTH: no entry, exc_taken=0, overflow and Status[31] set, and all other state is unchanged.
REQ-026 eret: exc_taken=1 and exc_addr=EPC combinationally.
REQ-027 eret with nest_level>0: on the next edge, EPC and Status are restored from stack[nest_level-1] and nest_level decrements; the overflow bit is kept.
REQ-028 eret with nest_level==0: exc_addr=EPC and no state change.
REQ-029 Priority within one cycle is eret, then synchronous exception, then interrupt, then mtc0; a lower-priority write in the same cycle is discarded.
REQ-030 mtc0 addr 12/13/14 writes Status/Cause/EPC per REQ-018..020; writing Status[31]=0 clears overflow; other addresses are ignored.
REQ-031 Handlers enable nesting by setting IE through mtc0.
REQ-032 rdata=selected register when mfc0=1 and addr is 12/13/14, else 0.
REQ-033 When neither eret nor acceptance is active, exc_taken=0 and exc_addr=0.

Reset
REQ-034 On rst: Status=32'h0000_000F (IE and all sync enables set, IM=0), Cause=0, EPC=0, nest_level=0, overflow=0, stack contents don't-care; exc_taken and exc_addr follow REQ-033.
REQ-035 rst asserted mid-nest discards all saved contexts immediately.

Verification
REQ-036 Syscall at pc=0x100 after reset -> exc_taken=1, exc_addr=VECTOR; next cycle EPC=0x100, Cause[6:2]=8, IE=0, nest_level=1; eret -> exc_addr=0x100, Status=0xF, nest_level=0.
REQ-037 IM=4'b0110, IE=1, irq pulse on lines 1 and 2 together -> line 1 taken (ExcCode 0, IP[1] cleared, IP[2] still set); after eret, line 2 is taken.
REQ-038 Nest to DEPTH (4) levels by setting IE in each handler; a fifth syscall -> exc_taken=0, overflow=1, Status[31]=1; four erets return the EPCs in LIFO order.
REQ-039 Same cycle: eret with exception=1 and mtc0 Status=0 -> eret wins, no push, Status is not written.
REQ-040 Break with Status[2]=0 -> ignored; eret at nest_level 0 with EPC=0x40 -> exc_addr=0x40, no state change; mfc0 addr 5 -> rdata=0.
REQ-041 Assert rst at nest_level=2 -> nest_level=0, Status=0xF, overflow=0 before the next edge.

Source files
------------

// File: rtl/cp0_nested_if.sv
// CP0 register-access and exception-control bundle between the pipeline and cp0_nested.
// i_* are driven by the pipeline (master); o_* are driven by the coprocessor (slave).
interface cp0_nested_if #(
  parameter int unsigned NUM_IRQ = 4
);
  logic               i_mfc0;
  logic               i_mtc0;
  logic [4:0]         i_addr;
  logic [31:0]        i_wdata;
  logic [31:0]        i_pc;
  logic               i_exception;
  logic [4:0]         i_cause;
  logic               i_eret;
  logic [NUM_IRQ-1:0] i_irq;
  logic [31:0]        o_rdata;
  logic [31:0]        o_status;
  logic [31:0]        o_exc_addr;
  logic               o_exc_taken;
  logic [3:0]         o_nest_level;
  logic               o_overflow;

  modport master (
    output i_mfc0, i_mtc0, i_addr, i_wdata, i_pc, i_exception, i_cause, i_eret, i_irq,
    input  o_rdata, o_status, o_exc_addr, o_exc_taken, o_nest_level, o_overflow
  );

  modport slave (
    input  i_mfc0, i_mtc0, i_addr, i_wdata, i_pc, i_exception, i_cause, i_eret, i_irq,
    output o_rdata, o_status, o_exc_addr, o_exc_taken, o_nest_level, o_overflow
  );
endinterface

// File: rtl/cp0_nested.sv
// CP0 with Status/Cause/EPC, prioritised exception/interrupt entry and a
// LIFO stack of saved {EPC, Status} contexts so handlers can nest.
module cp0_nested #(
  parameter int unsigned NUM_IRQ = 4,
  parameter int unsigned DEPTH   = 4,
  parameter logic [31:0] VECTOR  = 32'h0000_0004
) (
  input  logic            clk,
  input  logic            rst,
  cp0_nested_if.slave     bus
);
  localparam int unsigned IW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  ADDR_STATUS = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE  = 5'd13;
  localparam logic [4:0]  ADDR_EPC    = 5'd14;
  localparam logic [4:0]  EXC_SYS     = 5'd8;
  localparam logic [4:0]  EXC_BRK     = 5'd9;
  localparam logic [4:0]  EXC_TEQ     = 5'd13;

  logic               r_ie;
  logic [2:0]         r_en;
  logic [NUM_IRQ-1:0] r_im;
  logic [NUM_IRQ-1:0] r_ip;
  logic               r_ovf;
  logic [4:0]         r_code;
  logic [31:0]        r_epc;
  logic [3:0]         r_nest;
  logic [31:0]        r_stk_epc [DEPTH];
  logic [31:0]        r_stk_sts [DEPTH];

  logic [31:0]        w_status;
  logic [31:0]        w_cause;
  logic               w_cause_en;
  logic [NUM_IRQ-1:0] w_pend;
  logic [NUM_IRQ-1:0] w_irq_sel;
  logic [NUM_IRQ-1:0] w_ip_keep;
  logic               w_sync;
  logic               w_intr;
  logic               w_event;
  logic               w_full;
  logic               w_accept;
  logic               w_refuse;
  logic [IW-1:0]      w_push_idx;
  logic [IW-1:0]      w_pop_idx;

  // Architectural views of Status and Cause assembled from the field registers
  always_comb begin
    w_status                 = '0;
    w_status[0]              = r_ie;
    w_status[3:1]            = r_en;
    w_status[8 +: NUM_IRQ]   = r_im;
    w_status[31]             = r_ovf;
    w_cause                  = '0;
    w_cause[6:2]             = r_code;
    w_cause[8 +: NUM_IRQ]    = r_ip;
  end

  always_comb begin
    w_cause_en = 1'b0;
    case (bus.i_cause)
      EXC_SYS: w_cause_en = r_en[0];
      EXC_BRK: w_cause_en = r_en[1];
      EXC_TEQ: w_cause_en = r_en[2];
      default: w_cause_en = 1'b0;
    endcase
  end

  assign w_pend     = r_ip & r_im;
  assign w_irq_sel  = w_pend & (~w_pend + NUM_IRQ'(1));
  assign w_sync     = bus.i_exception & r_ie & w_cause_en;
  assign w_intr     = r_ie & (|w_pend);
  assign w_event    = ~bus.i_eret & (w_sync | w_intr);
  assign w_full     = (r_nest == 4'(DEPTH));
  assign w_accept   = w_event & ~w_full;
  assign w_refuse   = w_event & w_full;
  assign w_push_idx = IW'(r_nest);
  assign w_pop_idx  = IW'(r_nest - 4'd1);

  // A refused event still blocks a same-cycle mtc0
  always_comb begin
    w_ip_keep = '1;
    if (w_accept && !w_sync) begin
      w_ip_keep = ~w_irq_sel;
    end else if (bus.i_mtc0 && !bus.i_eret && !w_event && bus.i_addr == ADDR_CAUSE) begin
      w_ip_keep = bus.i_wdata[8 +: NUM_IRQ];
    end
  end

  always_comb begin
    bus.o_rdata = '0;
    if (bus.i_mfc0) begin
      case (bus.i_addr)
        ADDR_STATUS: bus.o_rdata = w_status;
        ADDR_CAUSE:  bus.o_rdata = w_cause;
        ADDR_EPC:    bus.o_rdata = r_epc;
        default:     bus.o_rdata = '0;
      endcase
    end
  end

  assign bus.o_exc_taken  = bus.i_eret | w_accept;
  assign bus.o_exc_addr   = bus.i_eret ? r_epc : (w_accept ? VECTOR : 32'h0);
  assign bus.o_status     = w_status;
  assign bus.o_nest_level = r_nest;
  assign bus.o_overflow   = r_ovf;

  // Context stack storage; contents are meaningless above r_nest so no reset
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_stk_epc[w_push_idx] <= r_epc;
      r_stk_sts[w_push_idx] <= w_status;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ie   <= 1'b1;
      r_en   <= 3'b111;
      r_im   <= '0;
      r_ip   <= '0;
      r_ovf  <= 1'b0;
      r_code <= '0;
      r_epc  <= '0;
      r_nest <= '0;
    end else begin
      r_ip <= (r_ip & w_ip_keep) | bus.i_irq;
      if (bus.i_eret) begin
        if (r_nest != 4'd0) begin
          r_epc  <= r_stk_epc[w_pop_idx];
          r_ie   <= r_stk_sts[w_pop_idx][0];
          r_en   <= r_stk_sts[w_pop_idx][3:1];
          r_im   <= r_stk_sts[w_pop_idx][8 +: NUM_IRQ];
          r_nest <= r_nest - 4'd1;
        end
      end else if (w_accept) begin
        r_epc  <= bus.i_pc;
        r_code <= w_sync ? bus.i_cause : 5'd0;
        r_ie   <= 1'b0;
        r_nest <= r_nest + 4'd1;
      end else if (w_refuse) begin
        r_ovf <= 1'b1;
      end else if (bus.i_mtc0) begin
        case (bus.i_addr)
          ADDR_STATUS: begin
            r_ie  <= bus.i_wdata[0];
            r_en  <= bus.i_wdata[3:1];
            r_im  <= bus.i_wdata[8 +: NUM_IRQ];
            r_ovf <= r_ovf & bus.i_wdata[31];
          end
          ADDR_CAUSE: r_code <= bus.i_wdata[6:2];
          ADDR_EPC:   r_epc  <= bus.i_wdata;
          default: ;
        endcase
      end
    end
  end
endmodule
